// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline definitions for the forwarding/hazard unit.
package fwd_hazard_unit_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;
  localparam fwd_sel_t FWD_RSVD  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side signal bundle of the forwarding/hazard unit.
interface fwd_hazard_unit_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_AW  = 5
);
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0]         ex_rd;
  logic                      ex_memread;
  logic                      ex_mc_start;
  logic [REG_AW-1:0]         mem_rd;
  logic                      mem_regwrite;
  logic [REG_AW-1:0]         wb_rd;
  logic                      wb_regwrite;
  logic                      flush;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall;
  logic                      bubble;
  logic                      ex_hold;
  logic                      mc_busy;
  logic                      mc_done;
  logic [REG_AW-1:0]         mc_rd;

  modport master (
    output id_valid, id_rs, ex_rs, ex_rd, ex_memread, ex_mc_start,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite, flush,
    input  fwd_sel, stall, bubble, ex_hold, mc_busy, mc_done, mc_rd
  );

  modport slave (
    input  id_valid, id_rs, ex_rs, ex_rd, ex_memread, ex_mc_start,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite, flush,
    output fwd_sel, stall, bubble, ex_hold, mc_busy, mc_done, mc_rd
  );
endinterface

// File: rtl/fwd_hazard_unit_mc_scoreboard.sv
// Tracks one in-flight multicycle op: state, latency counter and destination.
module mc_scoreboard
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = $clog2(MC_LAT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [REG_AW-1:0] start_rd,
  output logic              busy,
  output logic              done,
  output logic [REG_AW-1:0] rd
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 1);

  mc_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_q, rd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  // A start in the final busy cycle reloads without an idle gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          rd_d    = start_rd;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (start) begin
          cnt_d = CNT_LOAD;
          rd_d  = start_rd;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == BUSY);
  assign done = busy && (cnt_q == '0);
  assign rd   = rd_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selects plus load-use and multicycle-op hazard control.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_AW  = REG_AW_DEF,
  parameter int unsigned MC_LAT  = 4,
  parameter int unsigned CNT_W   = $clog2(MC_LAT)
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_unit_if.slave bus
);

  logic              mc_busy, mc_done;
  logic [REG_AW-1:0] mc_rd;
  logic              id_live, st;
  logic [NUM_SRC-1:0] lu_hit, raw_hit;
  fwd_sel_t          fwd_arr [NUM_SRC];

  mc_scoreboard #(
    .REG_AW (REG_AW),
    .MC_LAT (MC_LAT),
    .CNT_W  (CNT_W)
  ) u_mc_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (bus.ex_mc_start),
    .start_rd (bus.ex_rd),
    .busy     (mc_busy),
    .done     (mc_done),
    .rd       (mc_rd)
  );

  assign id_live = bus.id_valid && !bus.flush;

  // Per-operand compares; EX/MEM has priority over MEM/WB.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_AW-1:0] ers, irs;
    assign ers = bus.ex_rs[k*REG_AW +: REG_AW];
    assign irs = bus.id_rs[k*REG_AW +: REG_AW];

    assign fwd_arr[k] = (bus.mem_regwrite && bus.mem_rd != '0 && bus.mem_rd == ers) ? FWD_EXMEM :
                        (bus.wb_regwrite  && bus.wb_rd  != '0 && bus.wb_rd  == ers) ? FWD_MEMWB :
                        FWD_RF;

    assign lu_hit[k]  = bus.ex_memread && bus.ex_rd != '0 && id_live && bus.ex_rd == irs;
    assign raw_hit[k] = mc_busy && mc_rd != '0 && id_live && mc_rd == irs;
  end

  always_comb begin
    bus.fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.fwd_sel[i*2 +: 2] = fwd_arr[i];
    end
  end

  assign st = bus.ex_mc_start && mc_busy && !mc_done;

  assign bus.stall   = (|lu_hit) || (|raw_hit) || st;
  assign bus.bubble  = ((|lu_hit) || (|raw_hit)) && !st;
  assign bus.ex_hold = st;
  assign bus.mc_busy = mc_busy;
  assign bus.mc_done = mc_done;
  assign bus.mc_rd   = mc_rd;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: 2-operand and 3-operand instances.
module tb_fwd_hazard_unit;

  logic clk;
  logic rst_n;

  typedef struct packed {
    logic [5:0] fwd;
    logic       stall;
    logic       bubble;
    logic       hold;
    logic       busy;
    logic       done;
    logic [4:0] rd;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  fwd_hazard_unit_if #(.NUM_SRC(2), .REG_AW(5)) b2 ();
  fwd_hazard_unit_if #(.NUM_SRC(3), .REG_AW(5)) b3 ();

  fwd_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .MC_LAT(4)) u2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2)
  );

  fwd_hazard_unit #(.NUM_SRC(3), .REG_AW(5), .MC_LAT(4)) u3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(logic [5:0] f, logic s, logic bb, logic h,
                              logic bu, logic d, logic [4:0] r);
    exp_t e;
    e.fwd = f; e.stall = s; e.bubble = bb; e.hold = h;
    e.busy = bu; e.done = d; e.rd = r;
    return e;
  endfunction

  function automatic exp_t obs2();
    return {2'b00, b2.fwd_sel, b2.stall, b2.bubble, b2.ex_hold,
            b2.mc_busy, b2.mc_done, b2.mc_rd};
  endfunction

  function automatic exp_t obs3();
    return {b3.fwd_sel, b3.stall, b3.bubble, b3.ex_hold,
            b3.mc_busy, b3.mc_done, b3.mc_rd};
  endfunction

  task automatic drive_idle();
    b2.id_valid = 0; b2.id_rs = '0; b2.ex_rs = '0; b2.ex_rd = '0;
    b2.ex_memread = 0; b2.ex_mc_start = 0; b2.mem_rd = '0; b2.mem_regwrite = 0;
    b2.wb_rd = '0; b2.wb_regwrite = 0; b2.flush = 0;
    b3.id_valid = 0; b3.id_rs = '0; b3.ex_rs = '0; b3.ex_rd = '0;
    b3.ex_memread = 0; b3.ex_mc_start = 0; b3.mem_rd = '0; b3.mem_regwrite = 0;
    b3.wb_rd = '0; b3.wb_regwrite = 0; b3.flush = 0;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    drive_idle();
    rst_n = 1'b0;
    #3;
    sbq.push_back(mk(6'd0, 0, 0, 0, 0, 0, 5'd0));
    #1;
    o = obs2(); e = sbq.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset got=%h exp=%h", o, e); end
    o = obs3(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_n3 got=%h exp=%h", o, e); end
    apply_reset();
  endtask

  task automatic test_forwarding();
    exp_t e, o;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_idle();
      b2.mem_regwrite = 1; b2.wb_regwrite = 1;
      case (i)
        0: begin b2.mem_rd = 5; b2.wb_rd = 5; b2.ex_rs = {5'd0, 5'd5};
                 sbq.push_back(mk(6'b000010, 0, 0, 0, 0, 0, 0)); end
        1: begin b2.mem_rd = 5; b2.wb_rd = 5; b2.ex_rs = {5'd0, 5'd5}; b2.mem_regwrite = 0;
                 sbq.push_back(mk(6'b000001, 0, 0, 0, 0, 0, 0)); end
        2: begin b2.mem_rd = 0; b2.wb_rd = 0; b2.ex_rs = {5'd0, 5'd0};
                 sbq.push_back(mk(6'b000000, 0, 0, 0, 0, 0, 0)); end
        3: begin b2.mem_rd = 5; b2.wb_rd = 8; b2.ex_rs = {5'd8, 5'd5};
                 sbq.push_back(mk(6'b000110, 0, 0, 0, 0, 0, 0)); end
        default: begin b2.mem_rd = 5; b2.wb_rd = 5; b2.ex_rs = {5'd5, 5'd5};
                 sbq.push_back(mk(6'b001010, 0, 0, 0, 0, 0, 0)); end
      endcase
      @(negedge clk);
      o = obs2(); e = sbq.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL fwd case%0d got=%h exp=%h", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    exp_t e, o;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_idle();
      b2.ex_memread = (i != 1); b2.ex_rd = 7; b2.id_rs = {5'd7, 5'd2};
      b2.id_valid = (i != 3); b2.flush = (i == 2);
      if (i == 0) sbq.push_back(mk(6'd0, 1, 1, 0, 0, 0, 0));
      else        sbq.push_back(mk(6'd0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      o = obs2(); e = sbq.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL load_use case%0d got=%h exp=%h", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mc_timing();
    exp_t e, o;
    logic bsy;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_idle();
      b2.ex_mc_start = (i == 0); b2.ex_rd = 9;
      b2.id_valid = 1; b2.id_rs = {5'd0, 5'd9};
      bsy = (i >= 1 && i <= 4);
      sbq.push_back(mk(6'd0, bsy, bsy, 0, bsy, i == 4, (i >= 1) ? 5'd9 : 5'd0));
      @(negedge clk);
      o = obs2(); e = sbq.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL mc_timing cyc%0d got=%h exp=%h", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mc_zero_rd();
    exp_t e, o;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_idle();
      b2.ex_mc_start = (i == 0); b2.ex_rd = 0;
      b2.id_valid = 1; b2.id_rs = {5'd0, 5'd0};
      sbq.push_back(mk(6'd0, 0, 0, 0, i >= 1 && i <= 4, i == 4, 5'd0));
      @(negedge clk);
      o = obs2(); e = sbq.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL mc_zero_rd cyc%0d got=%h exp=%h", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive_idle();
      if (i == 0) begin
        b2.ex_mc_start = 1; b2.ex_rd = 3;
        sbq.push_back(mk(6'd0, 0, 0, 0, 0, 0, 5'd0));
      end else if (i == 1) begin
        sbq.push_back(mk(6'd0, 0, 0, 0, 1, 0, 5'd3));
      end else if (i <= 3) begin
        b2.ex_mc_start = 1; b2.ex_rd = 6;
        if (i == 3) begin b2.ex_memread = 1; b2.id_valid = 1; b2.id_rs = {5'd0, 5'd6}; end
        sbq.push_back(mk(6'd0, 1, 0, 1, 1, 0, 5'd3));
      end else if (i == 4) begin
        b2.ex_mc_start = 1; b2.ex_rd = 6;
        sbq.push_back(mk(6'd0, 0, 0, 0, 1, 1, 5'd3));
      end else begin
        sbq.push_back(mk(6'd0, 0, 0, 0, i <= 8, i == 8, 5'd6));
      end
      @(negedge clk);
      o = obs2(); e = sbq.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back cyc%0d got=%h exp=%h", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_op();
    exp_t e, o;
    apply_reset();
    b2.ex_mc_start = 1; b2.ex_rd = 9;
    @(posedge clk); #1;
    b2.ex_mc_start = 0;
    @(posedge clk); #1;
    sbq.push_back(mk(6'd0, 0, 0, 0, 1, 0, 5'd9));
    #1;
    o = obs2(); e = sbq.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL rst_mid pre got=%h exp=%h", o, e); end
    rst_n = 1'b0;
    sbq.push_back(mk(6'd0, 0, 0, 0, 0, 0, 5'd0));
    #1;
    o = obs2(); e = sbq.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL rst_mid async got=%h exp=%h", o, e); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sbq.push_back(mk(6'd0, 0, 0, 0, 0, 0, 5'd0));
      @(negedge clk);
      o = obs2(); e = sbq.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rst_mid post cyc%0d got=%h exp=%h", i, o, e); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_three_src();
    exp_t e, o;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      case (i)
        0: begin b3.ex_memread = 1; b3.ex_rd = 4; b3.id_valid = 1;
                 b3.id_rs = {5'd4, 5'd1, 5'd2};
                 sbq.push_back(mk(6'd0, 1, 1, 0, 0, 0, 0)); end
        1: begin b3.mem_regwrite = 1; b3.mem_rd = 12;
                 b3.ex_rs = {5'd12, 5'd3, 5'd1};
                 sbq.push_back(mk(6'b100000, 0, 0, 0, 0, 0, 0)); end
        default: begin b3.wb_regwrite = 1; b3.wb_rd = 12; b3.ex_memread = 1; b3.ex_rd = 4;
                 b3.id_valid = 1; b3.id_rs = {5'd5, 5'd1, 5'd2};
                 b3.ex_rs = {5'd12, 5'd3, 5'd1};
                 sbq.push_back(mk(6'b010000, 0, 0, 0, 0, 0, 0)); end
      endcase
      @(negedge clk);
      o = obs3(); e = sbq.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL three_src case%0d got=%h exp=%h", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_mc_timing();
    test_mc_zero_rd();
    test_back_to_back();
    test_reset_mid_op();
    test_three_src();
    if (sbq.size() != 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
